axil_fir_cfg_slave: RTL

- AXI-lite responder holding the FIR configuration space: ap_ctrl, data_length and the 11-entry tap coefficient RAM.
- Answers the fixed-order AXI-lite sequence issued by the WB-to-AXI bridge: AW then W for writes, AR then R for reads. There is no B channel.
- Drives the tap BRAM port and hands it to the FIR engine while the engine is busy.
- Generates ap_start and tracks ap_done and ap_idle.

---
 rtl/axil_fir_cfg_slave_if.sv | 29 ++
 rtl/axil_fir_cfg_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axil_fir_cfg_slave_if.sv
// AXI-lite write-address/write-data/read channels between the WB-to-AXI bridge and the FIR config slave.
// There is no B channel; the bridge never waits for a write response.
interface axil_fir_cfg_slave_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    input  awready, wready, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
    output awready, wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/axil_fir_cfg_slave.sv
// FIR configuration space behind AXI-lite: ap_ctrl, data_length and the tap coefficient BRAM port.
// The tap port belongs to the engine while it is busy and to the AXI side while idle.
module axil_fir_cfg_slave #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  axil_fir_cfg_slave_if.slave    axil,
  output logic                   ap_start,
  input  logic                   engine_done,
  output logic [pDATA_WIDTH-1:0] data_length,
  input  logic                   eng_tap_en,
  input  logic [pADDR_WIDTH-1:0] eng_tap_a,
  output logic [3:0]             tap_we,
  output logic                   tap_en,
  output logic [pADDR_WIDTH-1:0] tap_a,
  output logic [pDATA_WIDTH-1:0] tap_di,
  input  logic [pDATA_WIDTH-1:0] tap_do
);

  // Addresses are kept as word indices; the byte offset bits are never used.
  localparam int WW = pADDR_WIDTH - 2;
  localparam logic [WW-1:0]          A_CTRL   = '0;
  localparam logic [WW-1:0]          A_LEN    = WW'(4);
  localparam logic [WW-1:0]          A_TAP0   = WW'(8);
  localparam logic [WW-1:0]          A_TAPE   = WW'(8 + Tape_Num);
  localparam logic [pADDR_WIDTH-1:0] TAP_BASE = pADDR_WIDTH'(32);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_COMMIT} wst_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_WAIT, R_VALID} rst_e;

  function automatic logic is_tap(input logic [WW-1:0] w);
    return (w >= A_TAP0) && (w < A_TAPE);
  endfunction

  function automatic logic [pADDR_WIDTH-1:0] tap_off(input logic [WW-1:0] w);
    return {w, 2'b00} - TAP_BASE;
  endfunction

  wst_e                   wst_q, wst_d;
  logic [WW-1:0]          waddr_q, waddr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  rst_e                   rd_st_q, rd_st_d;
  logic [WW-1:0]          raddr_q, raddr_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic [pDATA_WIDTH-1:0] data_length_q, data_length_d;

  logic                   w_commit, tap_wr, r_fetch_tap, tap_rd, r_stall;
  logic [pDATA_WIDTH-1:0] reg_rd;

  assign w_commit    = (wst_q == W_COMMIT);
  assign tap_wr      = w_commit && is_tap(waddr_q) && ap_idle_q;
  assign r_fetch_tap = (rd_st_q == R_FETCH) && is_tap(raddr_q) && ap_idle_q;
  // A committing tap write owns the port; a tap read in the same cycle waits one cycle.
  assign tap_rd      = r_fetch_tap && !tap_wr;
  assign r_stall     = r_fetch_tap && tap_wr;

  assign axil.awready = (wst_q == W_IDLE) && !rst;
  assign axil.wready  = (wst_q == W_DATA) && !rst;
  assign axil.arready = (rd_st_q == R_IDLE) && !rst;
  assign axil.rvalid  = (rd_st_q == R_VALID) && !rst;
  assign axil.rdata   = rdata_q;
  assign ap_start     = ap_start_q;
  assign data_length  = data_length_q;

  always_comb begin
    tap_en = 1'b0;
    tap_we = 4'h0;
    tap_a  = '0;
    tap_di = '0;
    if (!rst) begin
      if (!ap_idle_q) begin
        tap_en = eng_tap_en;
        tap_a  = eng_tap_a;
      end else if (tap_wr) begin
        tap_en = 1'b1;
        tap_we = 4'hF;
        tap_a  = tap_off(waddr_q);
        tap_di = wdata_q;
      end else if (tap_rd) begin
        tap_en = 1'b1;
        tap_a  = tap_off(raddr_q);
      end
    end
  end

  always_comb begin
    reg_rd = '0;
    case (raddr_q)
      A_CTRL: begin
        reg_rd[2] = ap_idle_q;
        reg_rd[1] = ap_done_q;
      end
      A_LEN:   reg_rd = data_length_q;
      default: reg_rd = '0;
    endcase
  end

  always_comb begin
    wst_d   = wst_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (wst_q)
      W_IDLE: if (axil.awvalid) begin
        waddr_d = axil.awaddr[pADDR_WIDTH-1:2];
        wst_d   = W_DATA;
      end
      W_DATA: if (axil.wvalid) begin
        wdata_d = axil.wdata;
        wst_d   = W_COMMIT;
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    ap_start_d    = 1'b0;
    ap_done_d     = ap_done_q;
    ap_idle_d     = ap_idle_q;
    data_length_d = data_length_q;
    if (w_commit) begin
      if (waddr_q == A_CTRL && wdata_q[0] && ap_idle_q) begin
        ap_start_d = 1'b1;
        ap_idle_d  = 1'b0;
      end
      if (waddr_q == A_LEN) data_length_d = wdata_q;
    end
    if (rd_st_q == R_VALID && axil.rready && raddr_q == A_CTRL) ap_done_d = 1'b0;
    // A done pulse coinciding with the clearing read must not be lost.
    if (engine_done) begin
      ap_done_d = 1'b1;
      ap_idle_d = 1'b1;
    end
  end

  always_comb begin
    rd_st_d = rd_st_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    case (rd_st_q)
      R_IDLE: if (axil.arvalid) begin
        raddr_d = axil.araddr[pADDR_WIDTH-1:2];
        rd_st_d = R_FETCH;
      end
      R_FETCH: begin
        if (!is_tap(raddr_q)) begin
          rdata_d = reg_rd;
          rd_st_d = R_VALID;
        end else if (!ap_idle_q) begin
          rdata_d = '0;
          rd_st_d = R_VALID;
        end else if (!r_stall) begin
          rd_st_d = R_WAIT;
        end
      end
      R_WAIT: begin
        rdata_d = tap_do;
        rd_st_d = R_VALID;
      end
      R_VALID: if (axil.rready) rd_st_d = R_IDLE;
      default: rd_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wst_q         <= W_IDLE;
      waddr_q       <= '0;
      wdata_q       <= '0;
      rd_st_q       <= R_IDLE;
      raddr_q       <= '0;
      rdata_q       <= '0;
      ap_start_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      ap_idle_q     <= 1'b1;
      data_length_q <= '0;
    end else begin
      wst_q         <= wst_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      rd_st_q       <= rd_st_d;
      raddr_q       <= raddr_d;
      rdata_q       <= rdata_d;
      ap_start_q    <= ap_start_d;
      ap_done_q     <= ap_done_d;
      ap_idle_q     <= ap_idle_d;
      data_length_q <= data_length_d;
    end
  end

endmodule
